mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the single main-memory port between the I-cache fill FSM and the D-cache fill FSM/write-through path. It sits between both caches and main memory. It grants the port to one requester for a whole transaction: an 8-word block fill, or a single-cycle write-through store. It also routes returning read data valids to the owning cache only.

## Interface
- FILL_WORDS, 8, words per block fill; a fill completes after this many mem_data_valid pulses.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  I-cache requests a fill; held high until fill ends.
- i_addr  in  16  I-cache memory address; may change every cycle during a fill.
- d_req  in  1  D-cache requests a fill (d_wrt=0) or a store (d_wrt=1).
- d_wrt  in  1  qualifies d_req as a write-through store.
- d_addr  in  16  D-cache memory address.
- d_wdata  in  16  store data.
- mem_data_valid  in  1  memory read data valid.
- mem_rdata  in  16  memory read data.
- i_grant  out  1  I-cache owns the port (registered).
- d_grant  out  1  D-cache owns the port (registered).
- i_data_valid  out  1  mem_data_valid routed to I-cache.
- d_data_valid  out  1  mem_data_valid routed to D-cache.
- rd_data  out  16  mem_rdata passthrough to both caches.
- mem_enable  out  1  memory access strobe.
- mem_wr  out  1  memory write.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.

## Operation
- States: IDLE, I_FILL, D_FILL, D_WRITE. A registered last_owner bit holds I or D.
- IDLE arbitration:
  - Only one requester active: it wins.
  - Both active: the requester that is not last_owner wins.
  - Winner D with d_wrt=1 goes to D_WRITE. Winner D with d_wrt=0 goes to D_FILL. Winner I goes to I_FILL.
  - last_owner updates to the winner.
- I_FILL / D_FILL:
  - The matching grant is high.
  - mem_enable = owner's req; mem_wr=0; mem_addr = owner's addr.
  - The fill counter increments on each mem_data_valid.
  - On the FILL_WORDS-th valid, the next state is IDLE.
- Owner drops req mid-fill:
  - Grant stays high and mem_enable goes low.
  - Counting continues until FILL_WORDS valids have drained. No early release.
- D_WRITE: lasts exactly one cycle.
  - d_grant=1, mem_enable=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata.
  - Next state is IDLE.
- Valid routing:
  - i_data_valid = mem_data_valid & I_FILL.
  - d_data_valid = mem_data_valid & D_FILL.
  - A valid arriving in IDLE or D_WRITE is dropped.
- When not granted, mem_addr and mem_wdata are 0, and mem_enable and mem_wr are 0.
- Counter: width clog2(FILL_WORDS)+1; cleared on entry to any fill state.

## Timing
- Reset values:
  - state=IDLE, last_owner=I, so D wins the first tie.
  - Counter is 0.
  - All outputs are 0 (rd_data follows mem_rdata).
- Grant latency: req sampled high in IDLE at edge t gives grant and memory access in cycle t+1.
- Release: the 8th valid in cycle n puts the FSM in IDLE in n+1. A new grant is possible in n+2, giving one dead cycle between transactions.
- Back-to-back stores from D with I waiting: I wins the next arbitration (round robin).
- Reset mid-operation: IDLE and all outputs 0 on the next cycle. Later stray valids are not routed.
- Grants are mutually exclusive in every cycle.
- Routed valids and memory strobes are combinational from state and inputs.

## Structure
- Package mem_arb_pkg: state enum (IDLE, I_FILL, D_FILL, D_WRITE), FILL_WORDS default, owner encoding constants.
- Sub-module fill_word_counter: clear, increment, and a done flag at FILL_WORDS.
- Arbitration and output muxing stay in mem_arbiter.

## Test plan
- I fill alone:
  - Stimulus: i_req high at cycle 1, i_addr 0x0040…0x004E; memory returns 8 valids at cycles 6–13.
  - Response: i_grant high cycles 2–13; i_data_valid high on those 8 cycles; i_grant 0 at 14.
- Tie after reset:
  - Stimulus: i_req and d_req (d_wrt=0) both high at cycle 1.
  - Response: d_grant at 2. After D's 8 valids, i_grant follows with one dead cycle.
- Store:
  - Stimulus: d_req=1, d_wrt=1, d_addr=0x1234, d_wdata=0xBEEF.
  - Response: one cycle with mem_enable=1, mem_wr=1, mem_addr=0x1234, mem_wdata=0xBEEF, d_grant=1; IDLE next cycle.
- Round robin:
  - Stimulus: both hold stores continuously.
  - Response: grants alternate D, I, D, I, each separated by an IDLE cycle.
- Req drop:
  - Stimulus: i_req falls after 3 valids.
  - Response: mem_enable=0; i_grant holds until 5 more valids; then IDLE.
- Reset mid-fill:
  - Stimulus: rst pulse after 4 valids, then stray valids.
  - Response: all outputs 0; no routed valid; the next i_req is granted normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester main-memory arbiter.
package mem_arb_pkg;

  // Words delivered by memory for one cache block fill.
  localparam int FILL_WORDS = 8;
  // Fill counter width: wide enough to hold the value FILL_WORDS itself.
  localparam int CNT_W = $clog2(FILL_WORDS) + 1;

  // Encoding of the last_owner bit.
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_FILL  = 2'd1,
    D_FILL  = 2'd2,
    D_WRITE = 2'd3
  } arb_state_e;

  // Returns 1 when the D-cache wins arbitration. A lone requester always
  // wins; on a tie the requester that did not own the port last time wins.
  function automatic logic pick_d(input logic i_req, input logic d_req,
                                  input logic last_owner);
    logic win_d;
    if (d_req && !i_req) begin
      win_d = 1'b1;
    end else if (d_req && i_req) begin
      win_d = (last_owner == OWNER_I);
    end else begin
      win_d = 1'b0;
    end
    return win_d;
  endfunction

endpackage

// File: rtl/mem_arbiter_fill_word_counter.sv
// Counts returning read words of a block fill and flags the final one.
import mem_arb_pkg::*;

module fill_word_counter #(
  parameter int WORDS = FILL_WORDS,
  parameter int W     = CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic         done_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins over increment; hold otherwise.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = {W{1'b0}};
    end else if (inc_i) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  // High during the cycle that carries the WORDS-th word, so the owner
  // can release on the very next edge.
  assign done_o  = inc_i && !clear_i && (count_q == W'(WORDS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between the I-cache fill path and the
// D-cache fill / write-through path, one whole transaction at a time.
import mem_arb_pkg::*;

module mem_arbiter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_req_i,
  input  logic [15:0] i_addr_i,
  input  logic        d_req_i,
  input  logic        d_wrt_i,
  input  logic [15:0] d_addr_i,
  input  logic [15:0] d_wdata_i,
  input  logic        mem_data_valid_i,
  input  logic [15:0] mem_rdata_i,
  output logic        i_grant_o,
  output logic        d_grant_o,
  output logic        i_data_valid_o,
  output logic        d_data_valid_o,
  output logic [15:0] rd_data_o,
  output logic        mem_enable_o,
  output logic        mem_wr_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o
);

  arb_state_e     state_q, state_d;
  logic           last_owner_q, last_owner_d;
  logic           i_grant_q, d_grant_q;
  logic           in_fill_s;
  logic           fill_done_s;
  logic [CNT_W-1:0] fill_count_s;

  assign in_fill_s = (state_q == I_FILL) || (state_q == D_FILL);

  // Counter is held clear outside fills, so it starts at 0 on every entry.
  fill_word_counter #(
    .WORDS (FILL_WORDS),
    .W     (CNT_W)
  ) u_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (!in_fill_s),
    .inc_i   (mem_data_valid_i && in_fill_s),
    .count_o (fill_count_s),
    .done_o  (fill_done_s)
  );

  // Arbitration and transaction sequencing.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (i_req_i || d_req_i) begin
          if (pick_d(i_req_i, d_req_i, last_owner_q)) begin
            last_owner_d = OWNER_D;
            state_d      = d_wrt_i ? D_WRITE : D_FILL;
          end else begin
            last_owner_d = OWNER_I;
            state_d      = I_FILL;
          end
        end else begin
          state_d = IDLE;
        end
      end
      I_FILL, D_FILL: begin
        // No early release: a fill ends only when all words have drained.
        if (fill_done_s) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      D_WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, owner history and grant registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_owner_q <= OWNER_I;
      i_grant_q    <= 1'b0;
      d_grant_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      i_grant_q    <= (state_d == I_FILL);
      d_grant_q    <= (state_d == D_FILL) || (state_d == D_WRITE);
    end
  end

  // Memory port muxing and read-valid routing from the current owner.
  always_comb begin
    mem_enable_o   = 1'b0;
    mem_wr_o       = 1'b0;
    mem_addr_o     = 16'h0000;
    mem_wdata_o    = 16'h0000;
    i_data_valid_o = 1'b0;
    d_data_valid_o = 1'b0;
    case (state_q)
      I_FILL: begin
        mem_enable_o   = i_req_i;
        mem_addr_o     = i_addr_i;
        i_data_valid_o = mem_data_valid_i;
      end
      D_FILL: begin
        mem_enable_o   = d_req_i;
        mem_addr_o     = d_addr_i;
        d_data_valid_o = mem_data_valid_i;
      end
      D_WRITE: begin
        mem_enable_o = 1'b1;
        mem_wr_o     = 1'b1;
        mem_addr_o   = d_addr_i;
        mem_wdata_o  = d_wdata_i;
      end
      default: begin
        mem_enable_o = 1'b0;
      end
    endcase
  end

  assign i_grant_o = i_grant_q;
  assign d_grant_o = d_grant_q;
  assign rd_data_o = mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic        d_req;
  logic        d_wrt;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        mem_data_valid;
  logic [15:0] mem_rdata;
  logic        i_grant, d_grant, i_data_valid, d_data_valid;
  logic [15:0] rd_data;
  logic        mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_wdata;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .i_req_i          (i_req),
    .i_addr_i         (i_addr),
    .d_req_i          (d_req),
    .d_wrt_i          (d_wrt),
    .d_addr_i         (d_addr),
    .d_wdata_i        (d_wdata),
    .mem_data_valid_i (mem_data_valid),
    .mem_rdata_i      (mem_rdata),
    .i_grant_o        (i_grant),
    .d_grant_o        (d_grant),
    .i_data_valid_o   (i_data_valid),
    .d_data_valid_o   (d_data_valid),
    .rd_data_o        (rd_data),
    .mem_enable_o     (mem_enable),
    .mem_wr_o         (mem_wr),
    .mem_addr_o       (mem_addr),
    .mem_wdata_o      (mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are then driven and,
  // after a further #1, outputs are sampled well away from the edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_req = 1'b0; i_addr = 16'h0000; d_req = 1'b0; d_wrt = 1'b0;
    d_addr = 16'h0000; d_wdata = 16'h0000; mem_data_valid = 1'b0;
    mem_rdata = 16'h0000;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    mem_rdata = 16'hA5A5;
    #1;
    n_cmp++;
    if ({i_grant, d_grant, i_data_valid, d_data_valid, mem_enable, mem_wr} !== 6'b000000) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 000000",
        {i_grant, d_grant, i_data_valid, d_data_valid, mem_enable, mem_wr});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata} !== 32'h0) begin
      n_err++; $display("FAIL reset_bus: addr %h wdata %h want 0", mem_addr, mem_wdata);
    end
    n_cmp++;
    if (rd_data !== 16'hA5A5) begin
      n_err++; $display("FAIL rd_data_pass: got %h want a5a5", rd_data);
    end
  endtask

  task automatic test_i_fill();
    do_reset();
    i_req = 1'b1; i_addr = 16'h0040;
    cyc(); #1;
    n_cmp++;
    if ({i_grant, d_grant, mem_enable, mem_wr} !== 4'b1010 || mem_addr !== 16'h0040) begin
      n_err++; $display("FAIL ifill_grant: g/d/en/wr %b addr %h want 1010 0040",
        {i_grant, d_grant, mem_enable, mem_wr}, mem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      n_cmp++;
      if (i_grant !== 1'b1 || i_data_valid !== 1'b0) begin
        n_err++; $display("FAIL ifill_wait: grant %b valid %b want 1 0", i_grant, i_data_valid);
      end
    end
    for (int k = 0; k < 8; k++) begin
      cyc();
      mem_data_valid = 1'b1; i_addr = 16'h0040 + 16'(2 * k);
      #1;
      n_cmp++;
      if (i_grant !== 1'b1 || i_data_valid !== 1'b1 || d_data_valid !== 1'b0 ||
          mem_addr !== 16'h0040 + 16'(2 * k)) begin
        n_err++; $display("FAIL ifill_word%0d: g %b iv %b dv %b addr %h", k,
          i_grant, i_data_valid, d_data_valid, mem_addr);
      end
    end
    cyc();
    mem_data_valid = 1'b0; i_req = 1'b0;
    #1;
    n_cmp++;
    if ({i_grant, mem_enable} !== 2'b00 || mem_addr !== 16'h0000) begin
      n_err++; $display("FAIL ifill_release: grant/en %b addr %h want 00 0000",
        {i_grant, mem_enable}, mem_addr);
    end
  endtask

  task automatic test_tie();
    do_reset();
    i_req = 1'b1; i_addr = 16'h0080; d_req = 1'b1; d_wrt = 1'b0; d_addr = 16'h2000;
    cyc(); #1;
    n_cmp++;
    if ({d_grant, i_grant} !== 2'b10 || mem_addr !== 16'h2000) begin
      n_err++; $display("FAIL tie_first: d/i %b addr %h want 10 2000", {d_grant, i_grant}, mem_addr);
    end
    for (int k = 0; k < 8; k++) begin
      cyc();
      mem_data_valid = 1'b1;
      #1;
      n_cmp++;
      if ({d_grant, d_data_valid, i_data_valid} !== 3'b110) begin
        n_err++; $display("FAIL tie_dword%0d: dg/dv/iv %b want 110", k,
          {d_grant, d_data_valid, i_data_valid});
      end
    end
    cyc();
    mem_data_valid = 1'b0; d_req = 1'b0;
    #1;
    n_cmp++;
    if ({d_grant, i_grant, mem_enable} !== 3'b000) begin
      n_err++; $display("FAIL tie_dead: d/i/en %b want 000", {d_grant, i_grant, mem_enable});
    end
    cyc(); #1;
    n_cmp++;
    if ({d_grant, i_grant} !== 2'b01 || mem_addr !== 16'h0080) begin
      n_err++; $display("FAIL tie_second: d/i %b addr %h want 01 0080", {d_grant, i_grant}, mem_addr);
    end
  endtask

  task automatic test_store();
    do_reset();
    d_req = 1'b1; d_wrt = 1'b1; d_addr = 16'h1234; d_wdata = 16'hBEEF;
    cyc();
    d_req = 1'b0; mem_data_valid = 1'b1;
    #1;
    n_cmp++;
    if ({d_grant, mem_enable, mem_wr, d_data_valid} !== 4'b1110 ||
        mem_addr !== 16'h1234 || mem_wdata !== 16'hBEEF) begin
      n_err++; $display("FAIL store_cycle: g/en/wr/dv %b addr %h wdata %h want 1110 1234 beef",
        {d_grant, mem_enable, mem_wr, d_data_valid}, mem_addr, mem_wdata);
    end
    cyc();
    mem_data_valid = 1'b0;
    #1;
    n_cmp++;
    if ({d_grant, mem_enable, mem_wr} !== 3'b000 || mem_wdata !== 16'h0000) begin
      n_err++; $display("FAIL store_after: g/en/wr %b wdata %h want 000 0000",
        {d_grant, mem_enable, mem_wr}, mem_wdata);
    end
  endtask

  task automatic test_round_robin();
    logic exp_d, exp_i;
    do_reset();
    d_req = 1'b1; d_wrt = 1'b1; d_addr = 16'h3000; i_req = 1'b1; i_addr = 16'h0200;
    mem_data_valid = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      cyc(); #1;
      exp_d = (c == 1) || (c == 12);
      exp_i = (c >= 3 && c <= 10) || (c == 14);
      n_cmp++;
      if ({d_grant, i_grant, i_data_valid, mem_wr} !== {exp_d, exp_i, exp_i, exp_d}) begin
        n_err++; $display("FAIL rr_cycle%0d: dg/ig/iv/wr %b want %b", c,
          {d_grant, i_grant, i_data_valid, mem_wr}, {exp_d, exp_i, exp_i, exp_d});
      end
    end
    d_req = 1'b0; i_req = 1'b0; mem_data_valid = 1'b0;
  endtask

  task automatic test_req_drop();
    do_reset();
    i_req = 1'b1; i_addr = 16'h0100;
    cyc();
    for (int k = 0; k < 3; k++) begin
      cyc();
      mem_data_valid = 1'b1;
    end
    for (int k = 0; k < 5; k++) begin
      cyc();
      i_req = 1'b0;
      #1;
      n_cmp++;
      if ({i_grant, mem_enable, i_data_valid} !== 3'b101) begin
        n_err++; $display("FAIL drop_word%0d: g/en/iv %b want 101", k,
          {i_grant, mem_enable, i_data_valid});
      end
    end
    cyc();
    mem_data_valid = 1'b0;
    #1;
    n_cmp++;
    if (i_grant !== 1'b0) begin
      n_err++; $display("FAIL drop_release: grant %b want 0", i_grant);
    end
  endtask

  task automatic test_reset_mid_fill();
    do_reset();
    i_req = 1'b1; i_addr = 16'h0300;
    cyc();
    for (int k = 0; k < 4; k++) begin
      cyc();
      mem_data_valid = 1'b1;
    end
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; i_req = 1'b0;
    #1;
    n_cmp++;
    if ({i_grant, d_grant, i_data_valid, d_data_valid, mem_enable, mem_wr} !== 6'b000000 ||
        mem_addr !== 16'h0000) begin
      n_err++; $display("FAIL rstmid_outputs: %b addr %h want 000000 0000",
        {i_grant, d_grant, i_data_valid, d_data_valid, mem_enable, mem_wr}, mem_addr);
    end
    cyc();
    i_req = 1'b1; mem_data_valid = 1'b1;
    #1;
    n_cmp++;
    if ({i_grant, i_data_valid} !== 2'b00) begin
      n_err++; $display("FAIL rstmid_stray: g/iv %b want 00", {i_grant, i_data_valid});
    end
    cyc();
    mem_data_valid = 1'b0;
    #1;
    n_cmp++;
    if (i_grant !== 1'b1 || mem_addr !== 16'h0300) begin
      n_err++; $display("FAIL rstmid_regrant: grant %b addr %h want 1 0300", i_grant, mem_addr);
    end
    // A full 8-word fill must follow: the counter restarted from zero.
    for (int k = 0; k < 8; k++) begin
      cyc();
      mem_data_valid = 1'b1;
      #1;
      n_cmp++;
      if (i_grant !== 1'b1) begin
        n_err++; $display("FAIL rstmid_word%0d: grant %b want 1", k, i_grant);
      end
    end
    cyc();
    mem_data_valid = 1'b0; i_req = 1'b0;
    #1;
    n_cmp++;
    if (i_grant !== 1'b0) begin
      n_err++; $display("FAIL rstmid_release: grant %b want 0", i_grant);
    end
  endtask

  // Grants must never overlap in any cycle.
  always @(negedge clk) begin
    if (!rst && i_grant === 1'b1 && d_grant === 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL grant_exclusive: i %b d %b want not both", i_grant, d_grant);
    end
  end

  initial begin
    test_reset();
    test_i_fill();
    test_tie();
    test_store();
    test_round_robin();
    test_req_drop();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
